// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the ALU sharing arbiter: ALU op codes, FSM states, port IDs.
package alu_share_arbiter_pkg;

  localparam logic [2:0] AluOpAnd = 3'b000;
  localparam logic [2:0] AluOpOr  = 3'b001;
  localparam logic [2:0] AluOpAdd = 3'b010;
  localparam logic [2:0] AluOpSub = 3'b110;
  localparam logic [2:0] AluOpSlt = 3'b111;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam logic PortId0 = 1'b0;
  localparam logic PortId1 = 1'b1;

endpackage

// File: rtl/Arithmetic_Logic_Unit.sv
// Combinational 32-bit MIPS ALU: AND, OR, ADD, SUB, signed SLT; other codes pass operand A.
module Arithmetic_Logic_Unit
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic [2:0]       alu_control_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);

  logic slt;

  assign slt = ($signed(src_a_i) < $signed(src_b_i));

  always_comb begin
    result_o = src_a_i;
    case (alu_control_i)
      AluOpAnd: result_o = src_a_i & src_b_i;
      AluOpOr:  result_o = src_a_i | src_b_i;
      AluOpAdd: result_o = src_a_i + src_b_i;
      AluOpSub: result_o = src_a_i - src_b_i;
      AluOpSlt: result_o = {{(WIDTH-1){1'b0}}, slt};
      default:  result_o = src_a_i;
    endcase
  end

  assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-port arbiter in front of one shared ALU; round-robin grant by default, fixed port-0
// priority when ALU_ARB_FIXED_PRIO_EN is defined.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid_i,
  output logic             req0_ready_o,
  input  logic [2:0]       req0_op_i,
  input  logic [WIDTH-1:0] req0_a_i,
  input  logic [WIDTH-1:0] req0_b_i,
  input  logic             req1_valid_i,
  output logic             req1_ready_o,
  input  logic [2:0]       req1_op_i,
  input  logic [WIDTH-1:0] req1_a_i,
  input  logic [WIDTH-1:0] req1_b_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic             rsp_id_o,
  output logic [WIDTH-1:0] rsp_result_o,
  output logic             rsp_zero_o,
  output logic             busy_o
);

  state_e           state_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;
  logic             rsp_valid_q, rsp_id_q, rsp_zero_q;
  logic [WIDTH-1:0] rsp_result_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic             rr_q;  // 1: port 1 wins the next contention
`endif

  logic             grant1, idle, accept;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;

  always_comb begin
`ifdef ALU_ARB_FIXED_PRIO_EN
    grant1 = req1_valid_i & ~req0_valid_i;
`else
    grant1 = req1_valid_i & (~req0_valid_i | rr_q);
`endif
    // Gated by rst_n so both readies read 0 while reset is held.
    idle         = rst_n & (state_q == StIdle);
    req0_ready_o = idle & req0_valid_i & ~grant1;
    req1_ready_o = idle & grant1;
    accept       = req0_ready_o | req1_ready_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= PortId0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= PortId0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_q         <= PortId0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            op_q    <= grant1 ? req1_op_i : req0_op_i;
            a_q     <= grant1 ? req1_a_i : req0_a_i;
            b_q     <= grant1 ? req1_b_i : req0_b_i;
            id_q    <= grant1 ? PortId1 : PortId0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            rr_q    <= ~grant1;
`endif
            state_q <= StExec;
          end
        end
        StExec: begin
          rsp_result_q <= alu_result;
          rsp_zero_q   <= alu_zero;
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          state_q      <= StResp;
        end
        StResp: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  Arithmetic_Logic_Unit #(
    .WIDTH(WIDTH)
  ) u_alu (
    .src_a_i      (a_q),
    .src_b_i      (b_q),
    .alu_control_i(op_q),
    .result_o     (alu_result),
    .zero_o       (alu_zero)
  );

  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_zero_o   = rsp_zero_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: vector table, directed corner cases and a
// randomized run against a transaction-level reference model.
module tb_alu_share_arbiter;

  localparam logic [2:0] OpAnd = 3'b000, OpOr = 3'b001, OpAdd = 3'b010;
  localparam logic [2:0] OpSub = 3'b110, OpSlt = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, busy;
  logic [31:0] rsp_result;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid_i(req0_valid),
    .req0_ready_o(req0_ready),
    .req0_op_i   (req0_op),
    .req0_a_i    (req0_a),
    .req0_b_i    (req0_b),
    .req1_valid_i(req1_valid),
    .req1_ready_o(req1_ready),
    .req1_op_i   (req1_op),
    .req1_a_i    (req1_a),
    .req1_b_i    (req1_b),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_id_o    (rsp_id),
    .rsp_result_o(rsp_result),
    .rsp_zero_o  (rsp_zero),
    .busy_o      (busy)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Reference model state: one outstanding transaction at most.
  bit          m_pending;
  int          m_age;
  logic        m_id;
  logic [31:0] m_res;
  bit          m_pref;
  bit          acc_seen;
  logic        acc_id;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t tv[12];

  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      OpAnd:   return a & b;
      OpOr:    return a | b;
      OpAdd:   return a + b;
      OpSub:   return a - b;
      OpSlt:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req0_ready"}, 32'(req0_ready), 32'd0);
    check({tag, " req1_ready"}, 32'(req1_ready), 32'd0);
    check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, " rsp_id"}, 32'(rsp_id), 32'd0);
    check({tag, " rsp_result"}, rsp_result, 32'd0);
    check({tag, " rsp_zero"}, 32'(rsp_zero), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
  endtask

  // Called mid-cycle: checks the DUT against the model, then advances the model over the
  // coming clock edge.
  task automatic model_check();
    bit g0, g1, resp;
    g0 = 1'b0;
    g1 = 1'b0;
    if (!m_pending) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      g1 = req1_valid && !req0_valid;
`else
      g1 = req1_valid && (!req0_valid || m_pref);
`endif
      g0 = req0_valid && !g1;
    end
    check("req0_ready", 32'(req0_ready), 32'(g0));
    check("req1_ready", 32'(req1_ready), 32'(g1));
    check("busy", 32'(busy), 32'(m_pending));
    resp = m_pending && (m_age >= 1);
    check("rsp_valid", 32'(rsp_valid), 32'(resp));
    if (resp) begin
      check("rsp_id", 32'(rsp_id), 32'(m_id));
      check("rsp_result", rsp_result, m_res);
      check("rsp_zero", 32'(rsp_zero), 32'(m_res == 32'd0));
    end
    acc_seen = 1'b0;
    if (resp && rsp_ready) begin
      m_pending = 1'b0;
    end else if (m_pending) begin
      m_age++;
    end else if (g0 || g1) begin
      m_pending = 1'b1;
      m_age     = 0;
      m_id      = g1;
      m_res     = g1 ? alu_ref(req1_op, req1_a, req1_b) : alu_ref(req0_op, req0_a, req0_b);
      m_pref    = !g1;
      acc_seen  = 1'b1;
      acc_id    = g1;
    end
  endtask

  task automatic cyc(input logic v0, input logic [2:0] o0, input logic [31:0] a0,
                     input logic [31:0] b0, input logic v1, input logic [2:0] o1,
                     input logic [31:0] a1, input logic [31:0] b1, input logic rr);
    @(posedge clk);
    #1;
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    rsp_ready  = rr;
    @(negedge clk);
    model_check();
  endtask

  task automatic idle_cyc(input logic rr);
    cyc(1'b0, OpAnd, 32'd0, 32'd0, 1'b0, OpAnd, 32'd0, 32'd0, rr);
  endtask

  logic        grants[$];
  logic [31:0] p1_b, p1_res;
  logic [31:0] bp_res;
  bit          first_seen;
  logic        first_id;

  initial begin
    tv[0]  = '{OpAdd, 32'd7,          32'd5,          32'd12,         1'b0};
    tv[1]  = '{OpAdd, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0};
    tv[2]  = '{OpSub, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0};
    tv[3]  = '{3'b011, 32'hDEAD_BEEF, 32'h1234_5678,  32'hDEAD_BEEF,  1'b0};
    tv[4]  = '{OpSub, 32'd9,          32'd9,          32'd0,          1'b1};
    tv[5]  = '{OpSlt, 32'hFFFF_FFFD,  32'd2,          32'd1,          1'b0};
    tv[6]  = '{OpSlt, 32'd2,          32'hFFFF_FFFD,  32'd0,          1'b1};
    tv[7]  = '{OpAnd, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0};
    tv[8]  = '{OpOr,  32'h0F0F_0000,  32'h0000_00F0,  32'h0F0F_00F0,  1'b0};
    tv[9]  = '{3'b100, 32'd0,         32'hFFFF_FFFF,  32'd0,          1'b1};
    tv[10] = '{3'b101, 32'h1234_5678, 32'd3,          32'h1234_5678,  1'b0};
    tv[11] = '{OpSlt, 32'h8000_0000,  32'h7FFF_FFFF,  32'd1,          1'b0};

    m_pending = 1'b0; m_age = 0; m_id = 1'b0; m_res = '0; m_pref = 1'b0;
    acc_seen = 1'b0; acc_id = 1'b0;

    // Reset with both requesters valid: readies must still read 0.
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_op = OpAdd; req0_a = 32'd1; req0_b = 32'd1;
    req1_valid = 1'b1; req1_op = OpAdd; req1_a = 32'd1; req1_b = 32'd1;
    rsp_ready = 1'b0;
    #2;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    model_check();

    // Single port-0 ADD: accept in cycle 0, response in cycle 2.
    cyc(1'b1, OpAdd, 32'd7, 32'd5, 1'b0, OpAnd, 32'd0, 32'd0, 1'b1);
    check("t1 accept p0", 32'(acc_seen && acc_id == 1'b0), 32'd1);
    idle_cyc(1'b1);
    check("t1 no rsp in exec", 32'(rsp_valid), 32'd0);
    idle_cyc(1'b1);
    check("t1 rsp_valid", 32'(rsp_valid), 32'd1);
    check("t1 rsp_result", rsp_result, 32'd12);
    check("t1 rsp_zero", 32'(rsp_zero), 32'd0);
    check("t1 rsp_id", 32'(rsp_id), 32'd0);
    idle_cyc(1'b1);
    check("t1 idle after rsp", 32'(busy), 32'd0);

    // Contention every cycle: p0 SUB 9-9, p1 SLT -3 < 2.
    for (int c = 0; c < 24; c++) begin
      cyc(1'b1, OpSub, 32'd9, 32'd9, 1'b1, OpSlt, 32'hFFFF_FFFD, 32'd2, 1'b1);
      if (acc_seen) grants.push_back(acc_id);
      if (rsp_valid) begin
        check("t2 result by id", rsp_result, rsp_id ? 32'd1 : 32'd0);
        check("t2 zero by id", 32'(rsp_zero), rsp_id ? 32'd0 : 32'd1);
      end
    end
    check("t2 grant count", 32'(grants.size()), 32'd8);
    foreach (grants[k]) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      check("t2 grant order", 32'(grants[k]), 32'd0);
`else
      // Port 0 won the last grant of the previous test, so port 1 leads here.
      check("t2 grant order", 32'(grants[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
`endif
    end

    // Backpressure: response held with rsp_ready low.
    cyc(1'b1, OpAdd, 32'h11, 32'h22, 1'b0, OpAnd, 32'd0, 32'd0, 1'b0);
    idle_cyc(1'b0);
    idle_cyc(1'b0);
    check("t3 rsp_valid", 32'(rsp_valid), 32'd1);
    bp_res = rsp_result;
    check("t3 rsp_result", bp_res, 32'h33);
    for (int c = 0; c < 5; c++) begin
      cyc(1'b1, OpOr, 32'd1, 32'd2, 1'b1, OpAnd, 32'd3, 32'd4, 1'b0);
      check("t3 held result", rsp_result, 32'h33);
      check("t3 held valid", 32'(rsp_valid), 32'd1);
      check("t3 ready0 low", 32'(req0_ready), 32'd0);
      check("t3 ready1 low", 32'(req1_ready), 32'd0);
      check("t3 busy", 32'(busy), 32'd1);
    end
    idle_cyc(1'b1);
    idle_cyc(1'b1);
    check("t3 idle after consume", 32'(busy), 32'd0);

    // Vector table, alternating the issuing port.
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) cyc(1'b1, tv[i].op, tv[i].a, tv[i].b, 1'b0, OpAnd, 32'd0, 32'd0, 1'b1);
      else cyc(1'b0, OpAnd, 32'd0, 32'd0, 1'b1, tv[i].op, tv[i].a, tv[i].b, 1'b1);
      check("tv accept", 32'(acc_seen), 32'd1);
      idle_cyc(1'b1);
      idle_cyc(1'b1);
      check("tv rsp_valid", 32'(rsp_valid), 32'd1);
      check("tv rsp_result", rsp_result, tv[i].res);
      check("tv rsp_zero", 32'(rsp_zero), 32'(tv[i].zero));
      check("tv rsp_id", 32'(rsp_id), 32'(i % 2));
    end

    // Reset pulsed during EXEC.
    cyc(1'b1, OpAdd, 32'd1, 32'd2, 1'b0, OpAnd, 32'd0, 32'd0, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check_reset_outputs("mid-exec rst");
    m_pending = 1'b0; m_pref = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    model_check();
    for (int c = 0; c < 3; c++) begin
      idle_cyc(1'b1);
      check("no stale rsp", 32'(rsp_valid), 32'd0);
    end

    // Contention after reset; port 1 operands keep changing until its own handshake.
    first_seen = 1'b0; first_id = 1'b1; p1_b = '0; p1_res = '0;
    for (int c = 0; c < 6; c++) begin
      cyc(1'b1, OpAnd, 32'd5, 32'd3, 1'b1, OpAdd, 32'd100, 32'(1000 + c * 7), 1'b1);
      if (acc_seen && !first_seen) begin
        first_seen = 1'b1;
        first_id = acc_id;
      end
      if (acc_seen && acc_id) p1_b = req1_b;
      if (rsp_valid && rsp_id) p1_res = rsp_result;
    end
    check("post-rst first grant", 32'(first_id), 32'd0);
    check("opchg b at handshake", p1_b, 32'd1021);
    check("opchg p1 result", p1_res, 32'd1121);
    idle_cyc(1'b1);

    // Randomized traffic against the model.
    for (int c = 0; c < 800; c++) begin
      logic [2:0] ops[8];
      logic [31:0] ra0, rb0, ra1, rb1;
      ops = '{OpAnd, OpOr, OpAdd, OpSub, OpSlt, 3'b011, 3'b100, 3'b101};
      ra0 = ($urandom % 2) ? $urandom : 32'($urandom_range(0, 3));
      rb0 = ($urandom % 2) ? $urandom : 32'($urandom_range(0, 3));
      ra1 = ($urandom % 2) ? $urandom : 32'($urandom_range(0, 3));
      rb1 = ($urandom % 2) ? $urandom : 32'($urandom_range(0, 3));
      cyc(1'($urandom % 2), ops[$urandom % 8], ra0, rb0,
          1'($urandom % 2), ops[$urandom % 8], ra1, rb1, 1'(($urandom % 4) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
